// File: rtl/ps2_key_decoder_if.sv
// Key-event stream from the PS/2 decoder to its consumer.
// The head event stays stable while ev_valid is high. It is popped on ev_valid && ev_ready.
interface ps2_key_decoder_if;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       ev_ready;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_break,
    output ev_ext,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_break,
    input  ev_ext,
    output ev_ready
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key decoder.
// Raw lines are synchronised, and the clock is glitch-filtered. 11-bit frames are
// received and checked, and make/break/E0 sequences are decoded. Status is tracked
// for a set of keys, and every decoded event is queued in a small FWFT FIFO.
//
// Receiver states:
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | waiting for a start bit (data 0 on a strobe)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking odd parity and the stop bit
module ps2_key_decoder #(
  parameter int                     NUM_KEYS       = 3,
  parameter logic [NUM_KEYS*8-1:0]  KEY_CODES      = {8'h23, 8'h1B, 8'h1C},
  parameter int                     FILTER_LEN     = 8,
  parameter int                     TIMEOUT_CYCLES = 50000,
  parameter int                     FIFO_DEPTH     = 4
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                PS2_CLK,
  input  logic                PS2_DAT,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] released,
  output logic                frame_err,
  output logic                ev_overflow,
  ps2_key_decoder_if.master   ev
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and clock filter
  // ---------------------------------------------------------------------------
  logic           clk_s1_q, clk_s2_q;
  logic           dat_s1_q, dat_s2_q;
  logic           filt_clk_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           filt_toggle;
  logic           sample_stb;

  // Two-flop synchronisers. They idle high like the bus, so reset does not look like an edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
    end
  end

  // The filtered clock changes on the FILTER_LEN-th consecutive sample that differs from it.
  assign filt_toggle = (clk_s2_q != filt_clk_q) &&
                       (filt_cnt_q == FCW'(FILTER_LEN - 1));
  // Data is stable while the bus clock is low, so the strobe samples it directly.
  assign sample_stb  = filt_toggle && filt_clk_q;

  // Filter state: the run-length counter and the filtered clock level.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s2_q == filt_clk_q) begin
      filt_cnt_q <= '0;
    end else if (filt_toggle) begin
      filt_clk_q <= clk_s2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FCW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_t      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           byte_done_q, byte_done_d;
  logic           frame_err_q, frame_err_d;

  // Receiver state register, plus the registered byte_done and frame_err pulses.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      rx_byte_q   <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      rx_byte_q   <= rx_byte_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next state: advances on sample strobes, with the inter-bit timeout as a down-counter.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    rx_byte_d   = rx_byte_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;

    if (sample_stb) begin
      to_cnt_d = TOW'(TIMEOUT_CYCLES - 1);
    end else if (state_q != S_IDLE) begin
      if (to_cnt_q == '0) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q - TOW'(1);
      end
    end

    if (sample_stb) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          if ((^{shift_q, par_q}) && dat_s2_q) begin
            byte_done_d = 1'b1;
            rx_byte_d   = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence decoder and key status
  // ---------------------------------------------------------------------------
  logic                ext_q, brk_q;
  logic                ev_fire;
  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] held_q, pressed_q, released_q;

  assign ev_fire = byte_done_q && (rx_byte_q != CODE_EXT) && (rx_byte_q != CODE_BRK);

  // Only non-extended events can match a tracked key.
  always_comb begin
    key_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_hit[i] = ev_fire && !ext_q && (rx_byte_q == KEY_CODES[8*i +: 8]);
    end
  end

  // Prefix flags: E0/F0 set them, any other byte consumes them, and a bad frame drops them.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_done_q) begin
      if (rx_byte_q == CODE_EXT) begin
        ext_q <= 1'b1;
      end else if (rx_byte_q == CODE_BRK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Held/pressed/released. Typematic repeats and breaks of keys not held give no pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      pressed_q  <= key_hit & ~held_q & {NUM_KEYS{~brk_q}};
      released_q <= key_hit &  held_q & {NUM_KEYS{ brk_q}};
      held_q     <= (held_q & ~key_hit) | (key_hit & {NUM_KEYS{~brk_q}});
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full;
  logic          fifo_pop;
  logic          fifo_push;
  logic          ovf_q;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign fifo_pop  = (count_q != '0) && ev.ev_ready;
  // A pop in the same cycle frees a slot, so the push to a full FIFO still lands.
  assign fifo_push = ev_fire && (!fifo_full || fifo_pop);

  // Pointers, occupancy and the overflow pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(fifo_push) - CW'(fifo_pop);
      ovf_q   <= ev_fire && fifo_full && !fifo_pop;
    end
  end

  // Entry storage, packed as {ext, brk, code}.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (fifo_push) begin
      mem_q[wr_ptr_q] <= {ext_q, brk_q, rx_byte_q};
    end
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_ext   = mem_q[rd_ptr_q][9];
  assign ev.ev_break = mem_q[rd_ptr_q][8];
  assign ev.ev_code  = mem_q[rd_ptr_q][7:0];

  assign held        = held_q;
  assign pressed     = pressed_q;
  assign released    = released_q;
  assign frame_err   = frame_err_q;
  assign ev_overflow = ovf_q;

endmodule
